pkt_fragmenter: RTL and testbench
=================================

# pkt_fragmenter

Downstream stage of the packet encapsulator in the send path. Captures one encapsulated packet per `valid_pkt_send` pulse and emits it as a sequence of fixed-width flits. Flits leave LSB-first over a valid/ready link toward the lane serializer. Reports completion to the send controller and counts packets it had to drop because it was busy.

## Interface
Parameters:
- `PKT_WIDTH`, 1041: width of the encapsulated packet.
- `FLIT_WIDTH`, 256: width of one output flit.
- `NUM_FLITS`, (PKT_WIDTH+FLIT_WIDTH-1)/FLIT_WIDTH: flits per packet (derived); 5 at defaults.
- `IDX_WIDTH`, $clog2(NUM_FLITS) (min 1): flit index width.
- `DROP_CNT_WIDTH`, 8: width of the drop counter.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `pkt_data` in PKT_WIDTH: packet from the encapsulator.
- `valid_pkt_send` in 1: one-cycle pulse; `pkt_data` is valid in that cycle.
- `flit_data` out FLIT_WIDTH: current flit.
- `flit_valid` out 1: `flit_data` is valid.
- `flit_ready` in 1: downstream accepts the flit when `flit_valid & flit_ready`.
- `flit_last` out 1: current flit is the final flit of the packet.
- `flit_idx` out IDX_WIDTH: index of the current flit (0 = LSB slice).
- `busy` out 1: high in any state other than IDLE.
- `done_frag` out 1: one-cycle pulse after the last flit is accepted.
- `pkt_drop` out 1: one-cycle pulse; a packet arrived while busy and was discarded.
- `drop_cnt` out DROP_CNT_WIDTH: saturating count of dropped packets.

## Operation
- FSM states:
  - IDLE→SEND on `valid_pkt_send`.
  - SEND→SEND on a handshake that is not the last flit; `flit_idx` increments.
  - SEND→DONE on the handshake of flit NUM_FLITS-1.
  - DONE→IDLE unconditionally.
- Capture: in IDLE with `valid_pkt_send`, `pkt_data` is stored in an internal register `pkt_reg` and `flit_idx` is set to 0.
- Flit slicing: flit i = `pkt_reg[i*FLIT_WIDTH +: FLIT_WIDTH]`.
  - The last flit carries the remaining PKT_WIDTH-(NUM_FLITS-1)*FLIT_WIDTH bits in its LSBs; its upper bits are zero.
  - `flit_data` is derived only from registers; there is no combinational path from `pkt_data` or `flit_ready`.
- `flit_valid` = (state==SEND). `flit_last` = `flit_valid` & (`flit_idx`==NUM_FLITS-1).
- Outside SEND, `flit_data` is zero.
- Hold rule: while `flit_valid` & !`flit_ready`, `flit_data`, `flit_idx` and `flit_last` stay stable.
- Drop: `valid_pkt_send` seen in SEND or DONE is discarded.
  - `pkt_reg` is not modified.
  - `pkt_drop` pulses the next cycle.
  - `drop_cnt` increments and saturates at all-ones.
- `done_frag` is high exactly in the DONE cycle.
- Reset values: state IDLE; `pkt_reg`, `flit_data` and `flit_idx` are 0; `flit_valid`, `flit_last`, `busy`, `done_frag` and `pkt_drop` are 0; `drop_cnt` is 0.
- Reset mid-packet: all outputs return to reset values asynchronously. The partially sent packet is abandoned and not resumed.

## Timing
- Pulse at cycle T in IDLE → `flit_valid`=1 with flit 0 in T+1.
- Best-case latency with `flit_ready` tied high:
  - Flits 0..NUM_FLITS-1 appear in cycles T+1..T+NUM_FLITS.
  - `done_frag` is high in T+NUM_FLITS+1.
  - The next packet can be accepted in T+NUM_FLITS+2 (state is IDLE again).
- Throughput: one flit per cycle while `flit_ready` is high. Per packet, NUM_FLITS+2 cycles minimum.
- A pulse arriving in the DONE cycle is a drop, not an accept.
- A pulse arriving in the same cycle reset deasserts is ignored.

## Test plan
- **Single packet, defaults, `flit_ready`=1.** Drive a pulse with `pkt_data` = {17'h1ABCD, 1024'h…ramp}.
  - Expect 5 consecutive flits, `flit_idx` 0..4, `flit_last` only on idx 4.
  - Flit 4 = 256'h1ABCD zero-extended.
  - `done_frag` one cycle after flit 4; `busy` low the cycle after.
- **Backpressure.** Hold `flit_ready`=0 for 3 cycles on flit 2.
  - `flit_data`, `flit_idx`=2 and `flit_valid` stable throughout.
  - Completion is delayed by exactly 3 cycles.
- **Drop while busy.** Send a second pulse during flit 1 and a third during DONE.
  - `pkt_drop` pulses twice; `drop_cnt`=2.
  - First packet's flits are unchanged.
- **Saturation.** With DROP_CNT_WIDTH=2, force 5 drops → `drop_cnt` holds 3.
- **Back-to-back.** Pulse, then the next pulse exactly NUM_FLITS+2 cycles later → both packets are fully emitted and `pkt_drop` never asserts.
- **Reset mid-packet.** Assert `rst` during flit 3 → `flit_valid`, `busy` and `drop_cnt` are 0 immediately. After release, a new packet starts at `flit_idx` 0.

Source files
------------

// File: rtl/pkt_fragmenter.sv
// Packet fragmenter: captures one encapsulated packet and emits it as
// LSB-first fixed-width flits over a valid/ready link.
module pkt_fragmenter #(
    parameter int PKT_WIDTH      = 1041,
    parameter int FLIT_WIDTH     = 256,
    parameter int NUM_FLITS      = (PKT_WIDTH + FLIT_WIDTH - 1) / FLIT_WIDTH,
    parameter int IDX_WIDTH      = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PKT_WIDTH-1:0]      pkt_data,
    input  logic                      valid_pkt_send,
    output logic [FLIT_WIDTH-1:0]     flit_data,
    output logic                      flit_valid,
    input  logic                      flit_ready,
    output logic                      flit_last,
    output logic [IDX_WIDTH-1:0]      flit_idx,
    output logic                      busy,
    output logic                      done_frag,
    output logic                      pkt_drop,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int PAD_WIDTH = NUM_FLITS * FLIT_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_FLITS - 1);

    logic [1:0]           state;
    logic [PKT_WIDTH-1:0] pkt_reg;
    logic [PAD_WIDTH-1:0] pkt_pad;
    logic                 handshake;

    // Zero padding makes the upper bits of the final flit read as zero.
    assign pkt_pad = PAD_WIDTH'(pkt_reg);

    assign flit_valid = (state == S_SEND);
    assign flit_last  = flit_valid && (flit_idx == LAST_IDX);
    assign busy       = (state != S_IDLE);
    assign done_frag  = (state == S_DONE);
    assign handshake  = flit_valid && flit_ready;

    always_comb begin
        flit_data = '0;
        if (state == S_SEND) begin
            for (int i = 0; i < NUM_FLITS; i++) begin
                if (flit_idx == IDX_WIDTH'(i)) begin
                    flit_data = pkt_pad[i*FLIT_WIDTH +: FLIT_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pkt_reg  <= '0;
            flit_idx <= '0;
            pkt_drop <= 1'b0;
            drop_cnt <= '0;
        end else begin
            pkt_drop <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (valid_pkt_send) begin
                        pkt_reg  <= pkt_data;
                        flit_idx <= '0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        if (flit_idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            flit_idx <= flit_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    flit_idx <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // Packets offered while busy are discarded and counted.
            if (valid_pkt_send && (state != S_IDLE)) begin
                pkt_drop <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_fragmenter.sv
// Self-checking bench for pkt_fragmenter: vector table, random traffic
// against a transaction model, saturation and mid-packet reset.
module tb_pkt_fragmenter;

    localparam int PW = 1041;
    localparam int FW = 256;
    localparam int NF = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pkt_data;
    logic          valid_pkt_send;
    logic          flit_ready;
    logic [FW-1:0] flit_data;
    logic          flit_valid;
    logic          flit_last;
    logic [2:0]    flit_idx;
    logic          busy;
    logic          done_frag;
    logic          pkt_drop;
    logic [7:0]    drop_cnt;

    logic          valid2;
    logic [FW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic [2:0]    s_idx;
    logic          s_busy;
    logic          s_done;
    logic          s_drop;
    logic [1:0]    s_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pkt_fragmenter dut (
        .clk(clk), .rst(rst), .pkt_data(pkt_data),
        .valid_pkt_send(valid_pkt_send), .flit_data(flit_data),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_last(flit_last), .flit_idx(flit_idx), .busy(busy),
        .done_frag(done_frag), .pkt_drop(pkt_drop), .drop_cnt(drop_cnt)
    );

    pkt_fragmenter #(.DROP_CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .pkt_data(pkt_data),
        .valid_pkt_send(valid2), .flit_data(s_data),
        .flit_valid(s_valid), .flit_ready(flit_ready),
        .flit_last(s_last), .flit_idx(s_idx), .busy(s_busy),
        .done_frag(s_done), .pkt_drop(s_drop), .drop_cnt(s_cnt)
    );

    // Transaction-level model of the expected behaviour
    bit          m_act;
    int          m_sent;
    bit          m_done;
    bit          m_drop;
    int          m_cnt;
    logic [PW-1:0] m_pkt;

    typedef struct {
        bit v; bit r; int din;
        bit ev; int eidx; bit elast; bit edone; bit ebusy;
        bit edrop; int ecnt; int cur;
    } vec_t;

    vec_t          tbl[19];
    logic [PW-1:0] pkts[3];

    task automatic chk(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] exp_flit(logic [PW-1:0] p, int i);
        logic [NF*FW-1:0] w;
        w = {{(NF*FW-PW){1'b0}}, p};
        w = w >> (i * FW);
        return w[FW-1:0];
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < 33; k++) p = (p << 32) | PW'($urandom);
        return p;
    endfunction

    task automatic model_reset();
        m_act = 0; m_sent = 0; m_done = 0; m_drop = 0; m_cnt = 0;
        m_pkt = '0;
    endtask

    // Called at a negedge: check this cycle, drive, advance one cycle.
    task automatic step(bit v, bit r, logic [PW-1:0] d);
        bit nd;
        chk("flit_valid", FW'(flit_valid), FW'(m_act));
        chk("busy", FW'(busy), FW'(m_act | m_done));
        chk("done_frag", FW'(done_frag), FW'(m_done));
        chk("pkt_drop", FW'(pkt_drop), FW'(m_drop));
        chk("drop_cnt", FW'(drop_cnt), FW'(m_cnt));
        if (m_act) begin
            chk("flit_idx", FW'(flit_idx), FW'(m_sent));
            chk("flit_last", FW'(flit_last), FW'(m_sent == NF - 1));
            chk("flit_data", flit_data, exp_flit(m_pkt, m_sent));
        end else begin
            chk("idle_data", flit_data, '0);
        end
        valid_pkt_send = v;
        flit_ready     = r;
        pkt_data       = d;
        @(posedge clk);
        m_drop = v && (m_act || m_done);
        if (m_drop && m_cnt < 255) m_cnt++;
        nd = 0;
        if (!m_act && !m_done && v) begin
            m_act = 1; m_sent = 0; m_pkt = d;
        end else if (m_act && r) begin
            if (m_sent == NF - 1) begin
                m_act = 0; nd = 1;
            end else begin
                m_sent++;
            end
        end
        m_done = nd;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        valid_pkt_send = 1'b0;
        valid2 = 1'b0;
        flit_ready = 1'b1;
        pkt_data = '0;
        model_reset();

        for (int i = 0; i < 128; i++) pkts[0][i*8 +: 8] = 8'(i);
        pkts[0][PW-1:1024] = 17'h1ABCD;
        pkts[1] = rand_pkt();
        pkts[2] = rand_pkt();

        //           v r din ev idx lst dn bsy drp cnt cur
        tbl[0]  = '{1,1,0, 0,0,0,0,0,0,0,0};
        tbl[1]  = '{0,1,0, 1,0,0,0,1,0,0,0};
        tbl[2]  = '{0,1,0, 1,1,0,0,1,0,0,0};
        tbl[3]  = '{0,1,0, 1,2,0,0,1,0,0,0};
        tbl[4]  = '{0,1,0, 1,3,0,0,1,0,0,0};
        tbl[5]  = '{0,1,0, 1,4,1,0,1,0,0,0};
        tbl[6]  = '{0,1,0, 0,0,0,1,1,0,0,0};
        tbl[7]  = '{1,1,1, 0,0,0,0,0,0,0,0};
        tbl[8]  = '{0,1,1, 1,0,0,0,1,0,0,1};
        tbl[9]  = '{1,1,2, 1,1,0,0,1,0,0,1};
        tbl[10] = '{0,0,1, 1,2,0,0,1,1,1,1};
        tbl[11] = '{0,0,1, 1,2,0,0,1,0,1,1};
        tbl[12] = '{0,0,1, 1,2,0,0,1,0,1,1};
        tbl[13] = '{0,1,1, 1,2,0,0,1,0,1,1};
        tbl[14] = '{0,1,1, 1,3,0,0,1,0,1,1};
        tbl[15] = '{0,1,1, 1,4,1,0,1,0,1,1};
        tbl[16] = '{1,1,2, 0,0,0,1,1,0,1,1};
        tbl[17] = '{0,1,1, 0,0,0,0,0,1,2,1};
        tbl[18] = '{0,1,1, 0,0,0,0,0,0,2,1};

        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", FW'(flit_valid), '0);
        chk("rst_busy", FW'(busy), '0);
        chk("rst_data", flit_data, '0);
        chk("rst_idx", FW'(flit_idx), '0);
        chk("rst_cnt", FW'(drop_cnt), '0);
        chk("rst_done", FW'(done_frag), '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            chk("t_valid", FW'(flit_valid), FW'(tbl[i].ev));
            chk("t_busy", FW'(busy), FW'(tbl[i].ebusy));
            chk("t_done", FW'(done_frag), FW'(tbl[i].edone));
            chk("t_drop", FW'(pkt_drop), FW'(tbl[i].edrop));
            chk("t_cnt", FW'(drop_cnt), FW'(tbl[i].ecnt));
            if (tbl[i].ev) begin
                chk("t_idx", FW'(flit_idx), FW'(tbl[i].eidx));
                chk("t_last", FW'(flit_last), FW'(tbl[i].elast));
                chk("t_data", flit_data,
                    exp_flit(pkts[tbl[i].cur], tbl[i].eidx));
            end
            if (i == 5) chk("flit4_const", flit_data, FW'(17'h1ABCD));
            step(tbl[i].v, tbl[i].r, pkts[tbl[i].din]);
        end

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 6) == 0, ($urandom % 4) != 0, rand_pkt());
        end

        for (int i = 0; i < 20; i++) step(0, 1, '0);
        step(1, 1, pkts[1]);
        for (int i = 0; i < 3; i++) step(0, 1, '0);
        chk("pre_rst_idx", FW'(flit_idx), FW'(3));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", FW'(flit_valid), '0);
        chk("mid_rst_busy", FW'(busy), '0);
        chk("mid_rst_cnt", FW'(drop_cnt), '0);
        chk("mid_rst_data", flit_data, '0);
        chk("mid_rst_idx", FW'(flit_idx), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, pkts[2]);
        chk("post_rst_idx", FW'(flit_idx), '0);
        chk("post_rst_data", flit_data, exp_flit(pkts[2], 0));

        for (int i = 0; i < 10; i++) step(0, 1, '0);
        for (int j = 0; j < 6; j++) begin
            valid2 = 1'b1;
            step(0, 0, pkts[0]);
            chk("sat_drop", FW'(s_drop), FW'(j > 0));
            chk("sat_cnt", FW'(s_cnt), FW'((j > 3) ? 3 : j));
        end
        valid2 = 1'b0;
        chk("sat_busy", FW'(s_busy), FW'(1));
        for (int i = 0; i < 10; i++) step(0, 1, '0);
        chk("sat_hold", FW'(s_cnt), FW'(3));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
